data_cache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between memory_access_unit (CPU side) and

---
 rtl/cache_pkg.sv | 37 +++
 rtl/data_cache_controller_if.sv | 30 +++
 rtl/dcache_line_array.sv | 78 +++++++
 rtl/data_cache_controller.sv | 153 +++++++++++++++
 tb/tb_data_cache_controller.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache constants, FSM encoding and block/word helpers
package cache_pkg;

   localparam int DEF_INDEX_BITS = 3;
   localparam int DEF_TAG_BITS   = 32 - DEF_INDEX_BITS - 4;
   localparam int BLOCK_BITS     = 128;
   localparam int WORD_BITS      = 32;
   localparam int WORD_SEL       = 2;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WRITEBACK = 3'd1;
   localparam logic [2:0] S_FETCH     = 3'd2;
   localparam logic [2:0] S_ALLOCATE  = 3'd3;
   localparam logic [2:0] S_FL_SCAN   = 3'd4;
   localparam logic [2:0] S_FL_WB     = 3'd5;
   localparam logic [2:0] S_FL_DONE   = 3'd6;

   function automatic logic [WORD_BITS-1:0] word_of(input logic [BLOCK_BITS-1:0] blk,
                                                    input logic [WORD_SEL-1:0]   sel);
      return blk[{sel, 5'b0} +: WORD_BITS];
   endfunction

   function automatic logic [BLOCK_BITS-1:0] put_word(input logic [BLOCK_BITS-1:0] blk,
                                                      input logic [WORD_SEL-1:0]   sel,
                                                      input logic [WORD_BITS-1:0]  w);
      logic [BLOCK_BITS-1:0] r;
      r = blk;
      r[{sel, 5'b0} +: WORD_BITS] = w;
      return r;
   endfunction

   // Block address = byte address without the 16-byte block offset.
   function automatic logic [27:0] block_of(input logic [31:0] addr);
      return addr[31:4];
   endfunction

endpackage

// File: rtl/data_cache_controller_if.sv
// rtl/data_cache_controller_if.sv - CPU-side and memory-side signals of the data cache
interface data_cache_controller_if;
   logic         read;
   logic         write;
   logic [31:0]  address;
   logic [31:0]  writedata;
   logic [31:0]  readdata;
   logic         busywait;
   logic         flush_req;
   logic         flush_busy;
   logic         flush_done;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   modport slave (
      input  read, write, address, writedata, flush_req, mem_readdata, mem_busywait,
      output readdata, busywait, flush_busy, flush_done,
      output mem_read, mem_write, mem_address, mem_writedata
   );

   modport master (
      output read, write, address, writedata, flush_req, mem_readdata, mem_busywait,
      input  readdata, busywait, flush_busy, flush_done,
      input  mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - data/tag/valid/dirty storage with comb. read and registered updates
module dcache_line_array
   import cache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = DEF_TAG_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [BLOCK_BITS-1:0] rd_block,
   input  logic [INDEX_BITS-1:0] cpu_index,
   input  logic                  word_we,
   input  logic [WORD_SEL-1:0]   word_sel,
   input  logic [WORD_BITS-1:0]  word_data,
   input  logic                  alloc_we,
   input  logic [TAG_BITS-1:0]   alloc_tag,
   input  logic [BLOCK_BITS-1:0] alloc_block,
   input  logic                  clean_we,
   input  logic [INDEX_BITS-1:0] clean_index,
   input  logic                  inval_all
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [BLOCK_BITS-1:0] data_q [LINES];
   logic [BLOCK_BITS-1:0] data_d [LINES];
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [TAG_BITS-1:0]   tag_d  [LINES];
   logic [LINES-1:0]      valid_q, valid_d;
   logic [LINES-1:0]      dirty_q, dirty_d;

   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_block = data_q[rd_index];

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (word_we) begin
         data_d[cpu_index]  = put_word(data_q[cpu_index], word_sel, word_data);
         dirty_d[cpu_index] = 1'b1;
      end
      if (alloc_we) begin
         data_d[cpu_index]  = alloc_block;
         tag_d[cpu_index]   = alloc_tag;
         valid_d[cpu_index] = 1'b1;
         dirty_d[cpu_index] = 1'b0;
      end
      if (clean_we) begin
         dirty_d[clean_index] = 1'b0;
      end
      if (inval_all) begin
         valid_d = '0;
      end
   end

   // Only the state bits need a reset; data and tags are gated by valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end
endmodule

// File: rtl/data_cache_controller.sv
// rtl/data_cache_controller.sv - direct-mapped write-back data cache FSM with whole-cache flush
module data_cache_controller
   import cache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
   input  logic                    clk,
   input  logic                    reset,
   data_cache_controller_if.slave  bus
);
   logic [2:0]            state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [BLOCK_BITS-1:0] fetch_q, fetch_d;
   logic                  flush_pend_q, flush_pend_d;

   logic [INDEX_BITS-1:0] cpu_idx, arr_idx;
   logic [TAG_BITS-1:0]   cpu_tag;
   logic                  cpu_req, flushing, hit;
   logic                  rd_valid, rd_dirty;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [BLOCK_BITS-1:0] rd_block;
   logic                  word_we, alloc_we, clean_we, inval_all;
   logic                  unused_addr_lsb;

   assign cpu_idx         = bus.address[4 +: INDEX_BITS];
   assign cpu_tag         = bus.address[31 -: TAG_BITS];
   assign cpu_req         = bus.read | bus.write;
   assign flushing        = (state_q == S_FL_SCAN) || (state_q == S_FL_WB) || (state_q == S_FL_DONE);
   assign arr_idx         = flushing ? ptr_q : cpu_idx;
   assign hit             = rd_valid && (rd_tag == cpu_tag);
   assign unused_addr_lsb = ^bus.address[1:0];

   dcache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_lines (
      .clk         (clk),
      .reset       (reset),
      .rd_index    (arr_idx),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_tag      (rd_tag),
      .rd_block    (rd_block),
      .cpu_index   (cpu_idx),
      .word_we     (word_we),
      .word_sel    (bus.address[3:2]),
      .word_data   (bus.writedata),
      .alloc_we    (alloc_we),
      .alloc_tag   (cpu_tag),
      .alloc_block (fetch_q),
      .clean_we    (clean_we),
      .clean_index (ptr_q),
      .inval_all   (inval_all)
   );

   always_comb begin
      state_d           = state_q;
      ptr_d             = ptr_q;
      fetch_d           = fetch_q;
      flush_pend_d      = flush_pend_q;
      word_we           = 1'b0;
      alloc_we          = 1'b0;
      clean_we          = 1'b0;
      inval_all         = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_address   = '0;
      bus.mem_writedata = '0;
      bus.busywait      = cpu_req && !(state_q == S_IDLE && hit);
      bus.readdata      = (state_q == S_IDLE && bus.read && hit) ? word_of(rd_block, bus.address[3:2]) : '0;
      bus.flush_busy    = flushing;
      bus.flush_done    = (state_q == S_FL_DONE);

      // A flush asked for while the CPU owns the cache waits until it is idle.
      if (bus.flush_req && !flushing) begin
         flush_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               if (hit) begin
                  word_we = bus.write;
               end else begin
                  state_d = (rd_valid && rd_dirty) ? S_WRITEBACK : S_FETCH;
               end
            end else if (bus.flush_req || flush_pend_q) begin
               state_d      = S_FL_SCAN;
               ptr_d        = '0;
               flush_pend_d = 1'b0;
            end
         end
         S_WRITEBACK: begin
            bus.mem_write     = 1'b1;
            bus.mem_address   = {rd_tag, cpu_idx};
            bus.mem_writedata = rd_block;
            if (!bus.mem_busywait) state_d = S_FETCH;
         end
         S_FETCH: begin
            bus.mem_read    = 1'b1;
            bus.mem_address = block_of(bus.address);
            if (!bus.mem_busywait) begin
               fetch_d = bus.mem_readdata;
               state_d = S_ALLOCATE;
            end
         end
         S_ALLOCATE: begin
            alloc_we = 1'b1;
            state_d  = S_IDLE;
         end
         S_FL_SCAN: begin
            if (rd_valid && rd_dirty) begin
               state_d = S_FL_WB;
            end else if (ptr_q == '1) begin
               state_d = S_FL_DONE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         S_FL_WB: begin
            bus.mem_write     = 1'b1;
            bus.mem_address   = {rd_tag, ptr_q};
            bus.mem_writedata = rd_block;
            if (!bus.mem_busywait) begin
               clean_we = 1'b1;
               if (ptr_q == '1) begin
                  state_d = S_FL_DONE;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = S_FL_SCAN;
               end
            end
         end
         S_FL_DONE: begin
            inval_all = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         fetch_q      <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         fetch_q      <= fetch_d;
         flush_pend_q <= flush_pend_d;
      end
   end
endmodule

// File: tb/tb_data_cache_controller.sv
// tb/tb_data_cache_controller.sv - randomized bench for data_cache_controller with word-level memory model
module tb_data_cache_controller;
   logic clk = 1'b0;
   logic reset;
   initial forever #5 clk = ~clk;

   data_cache_controller_if bus();
   data_cache_controller dut (.clk(clk), .reset(reset), .bus(bus.slave));

   int n_vec = 0;
   int n_err = 0;

   // Reference: CPU-visible words, backing blocks, and which blocks the cache should hold.
   logic [31:0]  gw [bit [29:0]];
   logic [127:0] bm [bit [27:0]];
   bit           res_valid [8];
   bit           res_dirty [8];
   logic [24:0]  res_tag [8];

   int           force_wait = -1;
   int           txn_cnt, txn_cyc, n_fetch, n_wb, fd_cnt;
   logic [27:0]  exp_fetch_blk, last_wb_addr, last_fetch_addr;
   logic [127:0] last_wb_data;
   int           last_stall;
   logic [31:0]  last_rdata;

   task automatic check_v(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_i(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   function automatic logic [127:0] mem_block(input logic [27:0] b);
      logic [127:0] r;
      if (bm.exists(b)) return bm[b];
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = init_word({b, 2'(w)});
      return r;
   endfunction

   function automatic logic [31:0] golden_word(input logic [31:0] a);
      logic [127:0] blk;
      if (gw.exists(a[31:2])) return gw[a[31:2]];
      blk = mem_block(a[31:4]);
      return blk[int'(a[3:2])*32 +: 32];
   endfunction

   function automatic logic [127:0] golden_block(input logic [27:0] b);
      logic [127:0] r;
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = golden_word({b, 2'(w), 2'b00});
      return r;
   endfunction

   // Memory: random (or forced) busy cycles per transaction, checks every completed transfer.
   initial begin
      bit       act = 0;
      int       wcnt = 0;
      bit [2:0] wi;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            act = 0;
            bus.mem_busywait = 1'b0;
         end else if (bus.mem_read || bus.mem_write) begin
            if (!act) begin
               act  = 1;
               wcnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            end
            txn_cyc++;
            if (wcnt > 0) begin
               bus.mem_busywait = 1'b1;
               wcnt--;
            end else begin
               bus.mem_busywait = 1'b0;
               act = 0;
               txn_cnt++;
               if (bus.mem_read) begin
                  bus.mem_readdata = mem_block(bus.mem_address);
                  last_fetch_addr  = bus.mem_address;
                  check_v("fetch_addr", 128'(bus.mem_address), 128'(exp_fetch_blk));
                  n_fetch++;
               end else begin
                  wi = bus.mem_address[2:0];
                  check_i("wb_is_dirty_line",
                          int'(res_valid[wi] && res_dirty[wi] && res_tag[wi] == bus.mem_address[27:3]), 1);
                  check_v("wb_data", bus.mem_writedata, golden_block(bus.mem_address));
                  bm[bus.mem_address] = bus.mem_writedata;
                  res_dirty[wi] = 0;
                  last_wb_addr  = bus.mem_address;
                  last_wb_data  = bus.mem_writedata;
                  n_wb++;
               end
            end
         end else begin
            act = 0;
            bus.mem_busywait = 1'b0;
         end
      end
   end

   // Compare process: CPU read data and bus invariants on every meaningful cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (bus.read && !bus.busywait)
               check_v("readdata", 128'(bus.readdata), 128'(golden_word(bus.address)));
            if (bus.mem_read || bus.mem_write)
               check_i("mem_rd_wr_exclusive", int'(bus.mem_read & bus.mem_write), 0);
            if (bus.flush_done) begin
               fd_cnt++;
               check_i("flush_busy_at_done", int'(bus.flush_busy), 1);
            end
         end
      end
   end

   task automatic model_invalidate();
      for (int i = 0; i < 8; i++) begin
         res_valid[i] = 0;
         res_dirty[i] = 0;
      end
   endtask

   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit with_flush);
      int          idx = int'(a[6:4]);
      logic [24:0] tg  = a[31:7];
      bit          hit;
      int          exp_txn;
      int          stall = 0;
      hit     = res_valid[idx] && res_tag[idx] == tg;
      exp_txn = hit ? 0 : ((res_valid[idx] && res_dirty[idx]) ? 2 : 1);
      exp_fetch_blk = a[31:4];
      txn_cnt = 0;
      txn_cyc = 0;
      bus.read      = !wr;
      bus.write     = wr;
      bus.address   = a;
      bus.writedata = d;
      bus.flush_req = with_flush;
      forever begin
         @(negedge clk);
         if (!bus.busywait) begin
            last_rdata = bus.readdata;
            break;
         end
         stall++;
         if (stall > 400) begin
            check_i("access_timeout", stall, 0);
            break;
         end
         @(posedge clk); #1;
         bus.flush_req = 1'b0;
      end
      @(posedge clk); #1;
      bus.read = 1'b0;
      bus.write = 1'b0;
      bus.flush_req = 1'b0;
      last_stall = stall;
      check_i("stall_cycles", stall, hit ? 0 : 2 + txn_cyc);
      check_i("mem_txns", txn_cnt, exp_txn);
      if (wr) gw[a[31:2]] = d;
      res_dirty[idx] = (hit ? res_dirty[idx] : 1'b0) | wr;
      res_valid[idx] = 1;
      res_tag[idx]   = tg;
   endtask

   task automatic flush_wait(input bit pulse);
      int exp_wb = 0;
      int cyc;
      for (int i = 0; i < 8; i++) if (res_valid[i] && res_dirty[i]) exp_wb++;
      txn_cnt = 0;
      txn_cyc = 0;
      fd_cnt  = 0;
      bus.flush_req = pulse;
      @(posedge clk); #1;
      bus.flush_req = 1'b0;
      cyc = 1;
      forever begin
         @(negedge clk);
         if (cyc == 1) check_i("flush_busy", int'(bus.flush_busy), 1);
         if (bus.flush_done) break;
         if (cyc > 600) begin
            check_i("flush_timeout", cyc, 0);
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check_i("flush_len", cyc, 9 + txn_cyc);
      @(posedge clk); #1;
      check_i("flush_busy_after", int'(bus.flush_busy), 0);
      check_i("flush_done_pulse", int'(bus.flush_done), 0);
      check_i("flush_done_count", fd_cnt, 1);
      check_i("flush_wb_count", txn_cnt, exp_wb);
      model_invalidate();
   endtask

   function automatic logic [31:0] rand_addr();
      return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
   endfunction

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] t128;
      int           wb0, waitc;
      reset = 1'b0;
      bus.read = 1'b0; bus.write = 1'b0; bus.flush_req = 1'b0;
      bus.address = '0; bus.writedata = '0;
      bus.mem_busywait = 1'b0; bus.mem_readdata = '0;
      n_fetch = 0; n_wb = 0; fd_cnt = 0;
      model_invalidate();
      repeat (3) @(posedge clk);
      #1;
      check_i("rst_busywait", int'(bus.busywait), 0);
      check_i("rst_mem_read", int'(bus.mem_read), 0);
      check_i("rst_mem_write", int'(bus.mem_write), 0);
      check_i("rst_flush_busy", int'(bus.flush_busy), 0);
      check_i("rst_flush_done", int'(bus.flush_done), 0);
      check_v("rst_readdata", 128'(bus.readdata), 128'h0);
      reset = 1'b1;

      // Directed scenarios with hand-computed results.
      force_wait = 3;
      bm[28'h004] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
      access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
      check_i("lit_miss_stall", last_stall, 6);
      check_v("lit_miss_data", 128'(last_rdata), 128'hDEADBEEF);
      check_i("lit_one_fetch", n_fetch, 1);
      force_wait = 1;
      access(1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0);
      check_i("lit_write_hit_stall", last_stall, 0);
      access(1'b0, 32'h0000_0044, 32'h0, 1'b0);
      check_v("lit_read_back", 128'(last_rdata), 128'h12345678);
      access(1'b0, 32'h0000_0840, 32'h0, 1'b0);
      check_v("lit_wb_addr", 128'(last_wb_addr), 128'h004);
      t128 = last_wb_data;
      check_v("lit_wb_word1", 128'(t128[63:32]), 128'h12345678);
      check_v("lit_fetch_addr", 128'(last_fetch_addr), 128'h084);
      access(1'b1, 32'h0000_0010, 32'hA5A5_0001, 1'b0);
      access(1'b1, 32'h0000_0020, 32'hA5A5_0002, 1'b0);
      wb0 = n_wb;
      flush_wait(1'b1);
      check_i("lit_flush_two_wb", n_wb - wb0, 2);
      access(1'b0, 32'h0000_0010, 32'h0, 1'b0);
      check_i("lit_miss_after_flush", int'(last_stall > 0), 1);
      access(1'b1, 32'h0000_0030, 32'hC0FF_EE00, 1'b0);
      access(1'b0, 32'h0000_01B0, 32'h0, 1'b1);
      flush_wait(1'b0);

      // Randomized traffic.
      force_wait = -1;
      for (int i = 0; i < 300; i++) begin
         int r = int'($urandom_range(0, 99));
         if (r < 5) begin
            flush_wait(1'b1);
         end else if (r < 9) begin
            access(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b1);
            flush_wait(1'b0);
         end else begin
            access(r < 50, rand_addr(), $urandom, 1'b0);
         end
      end

      // Reset while a fetch is outstanding loses dirty data and all lines.
      force_wait = 1;
      flush_wait(1'b1);
      access(1'b1, 32'h0000_0100, 32'h7777_1111, 1'b0);
      force_wait = 100;
      exp_fetch_blk = 28'h015;
      bus.read = 1'b1;
      bus.address = 32'h0000_0154;
      waitc = 0;
      while (bus.mem_read !== 1'b1 && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      check_i("fetch_started", int'(bus.mem_read), 1);
      reset = 1'b0;
      bus.read = 1'b0;
      @(posedge clk); #1;
      check_i("rst_mid_mem_read", int'(bus.mem_read), 0);
      check_i("rst_mid_busywait", int'(bus.busywait), 0);
      check_i("rst_mid_flush_busy", int'(bus.flush_busy), 0);
      reset = 1'b1;
      model_invalidate();
      gw.delete();
      force_wait = -1;
      access(1'b0, 32'h0000_0100, 32'h0, 1'b0);
      check_i("lit_miss_after_reset", int'(last_stall > 0), 1);
      for (int i = 0; i < 40; i++) access(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
